// File: rtl/inst_fetch_buffer_pkg.sv
// Shared constants and entry packing for the instruction fetch buffer.
// Optional same-cycle bypass is selected with the IFB_BYPASS_EN macro.
`ifndef SIZE_OF_CORR_PACK
`define SIZE_OF_CORR_PACK 16
`endif

package inst_fetch_buffer_pkg;

  localparam int IFB_DEPTH       = 16;
  localparam int IFB_INST_W      = 32;
  localparam int IFB_ADDR_W      = 32;
  localparam int IFB_CORR_W      = `SIZE_OF_CORR_PACK;
  localparam int IFB_FULL_THRESH = 4;

  typedef struct packed {
    logic [IFB_CORR_W-1:0] corr;
    logic [IFB_ADDR_W-1:0] addr;
    logic [IFB_INST_W-1:0] inst;
  } ifb_entry_t;

endpackage

// File: rtl/ifb_entry_ram.sv
// Fetch buffer entry storage: flop array, two write ports,
// two asynchronous read ports, no reset on contents.
module ifb_entry_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 80,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd0,
  output logic [W-1:0]  rd1
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Dual-issue instruction fetch buffer between ICache and decode.
// Define IFB_BYPASS_EN for zero-latency bypass when the buffer is empty.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = IFB_DEPTH,
  parameter int INST_W = IFB_INST_W,
  parameter int ADDR_W = IFB_ADDR_W,
  parameter int CORR_W = IFB_CORR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_inst1_valid_i,
  input  logic                       in_inst2_valid_i,
  input  logic [INST_W-1:0]          in_inst1_i,
  input  logic [INST_W-1:0]          in_inst2_i,
  input  logic [ADDR_W-1:0]          in_inst1_addr_i,
  input  logic [ADDR_W-1:0]          in_inst2_addr_i,
  input  logic [CORR_W-1:0]          in_corr0_i,
  input  logic [CORR_W-1:0]          in_corr1_i,
  output logic                       fetch_full_o,
  input  logic [1:0]                 issue_cnt_i,
  output logic                       out_inst1_valid_o,
  output logic                       out_inst2_valid_o,
  output logic [INST_W-1:0]          out_inst1_o,
  output logic [INST_W-1:0]          out_inst2_o,
  output logic [ADDR_W-1:0]          out_inst1_addr_o,
  output logic [ADDR_W-1:0]          out_inst2_addr_o,
  output logic [CORR_W-1:0]          out_corr0_o,
  output logic [CORR_W-1:0]          out_corr1_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = CORR_W + ADDR_W + INST_W;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, free;
  logic [1:0]    push_req, issue_c, pop_n, skip, wr_n;
  logic          push_ok, byp, we0, we1;
  logic [EW-1:0] e1, e2, wd0, rd0, rd1, o1, o2;
  logic          ov1, ov2;

  assign e1 = {in_corr0_i, in_inst1_addr_i, in_inst1_i};
  assign e2 = {in_corr1_i, in_inst2_addr_i, in_inst2_i};

  assign push_req = {1'b0, in_inst1_valid_i}
                  + {1'b0, in_inst1_valid_i & in_inst2_valid_i};
  assign issue_c  = (issue_cnt_i == 2'd3) ? 2'd2 : issue_cnt_i;
  assign pop_n    = (count < CW'(issue_c)) ? count[1:0] : issue_c;
  assign free     = CW'(DEPTH) - count;
  assign push_ok  = CW'(push_req) <= free;
  assign fetch_full_o = free < CW'(IFB_FULL_THRESH);

`ifdef IFB_BYPASS_EN
  assign byp  = rst & ~flush_i & (count == '0);
  assign skip = byp ? ((issue_c < push_req) ? issue_c : push_req)
                    : 2'd0;
`else
  assign byp  = 1'b0;
  assign skip = 2'd0;
`endif

  // Skipped (bypass-consumed) slots shift slot 2 down to the tail.
  assign wr_n = push_ok ? (push_req - skip) : 2'd0;
  assign we0  = ~flush_i & (wr_n != 2'd0);
  assign we1  = ~flush_i & (wr_n == 2'd2);
  assign wd0  = (skip != 2'd0) ? e2 : e1;

  ifb_entry_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk (clk),
    .we0 (we0),
    .wa0 (tail),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (tail + PW'(1)),
    .wd1 (e2),
    .ra0 (head),
    .ra1 (head + PW'(1)),
    .rd0 (rd0),
    .rd1 (rd1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(wr_n);
      head  <= head + PW'(pop_n);
      count <= count + CW'(wr_n) - CW'(pop_n);
    end
  end

  always_comb begin
    ov1 = count != '0;
    ov2 = count >= CW'(2);
    o1  = rd0;
    o2  = rd1;
    if (byp) begin
      ov1 = in_inst1_valid_i;
      ov2 = in_inst1_valid_i & in_inst2_valid_i;
      o1  = e1;
      o2  = e2;
    end
  end

  assign out_inst1_valid_o = ov1;
  assign out_inst2_valid_o = ov2;
  assign {out_corr0_o, out_inst1_addr_o, out_inst1_o} = ov1 ? o1 : '0;
  assign {out_corr1_o, out_inst2_addr_o, out_inst2_o} = ov2 ? o2 : '0;
  assign count_o = count;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    flush_i || push_ok
  );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized scoreboard bench for inst_fetch_buffer.
// Reference model is a plain queue of entries; honours IFB_BYPASS_EN.
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;

  localparam int D  = IFB_DEPTH;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst;
  logic flush_i;
  logic in_inst1_valid_i, in_inst2_valid_i;
  logic [IFB_INST_W-1:0] in_inst1_i, in_inst2_i;
  logic [IFB_ADDR_W-1:0] in_inst1_addr_i, in_inst2_addr_i;
  logic [IFB_CORR_W-1:0] in_corr0_i, in_corr1_i;
  logic fetch_full_o;
  logic [1:0] issue_cnt_i;
  logic out_inst1_valid_o, out_inst2_valid_o;
  logic [IFB_INST_W-1:0] out_inst1_o, out_inst2_o;
  logic [IFB_ADDR_W-1:0] out_inst1_addr_o, out_inst2_addr_o;
  logic [IFB_CORR_W-1:0] out_corr0_o, out_corr1_o;
  logic [CW-1:0] count_o;

  inst_fetch_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .in_inst1_valid_i  (in_inst1_valid_i),
    .in_inst2_valid_i  (in_inst2_valid_i),
    .in_inst1_i        (in_inst1_i),
    .in_inst2_i        (in_inst2_i),
    .in_inst1_addr_i   (in_inst1_addr_i),
    .in_inst2_addr_i   (in_inst2_addr_i),
    .in_corr0_i        (in_corr0_i),
    .in_corr1_i        (in_corr1_i),
    .fetch_full_o      (fetch_full_o),
    .issue_cnt_i       (issue_cnt_i),
    .out_inst1_valid_o (out_inst1_valid_o),
    .out_inst2_valid_o (out_inst2_valid_o),
    .out_inst1_o       (out_inst1_o),
    .out_inst2_o       (out_inst2_o),
    .out_inst1_addr_o  (out_inst1_addr_o),
    .out_inst2_addr_o  (out_inst2_addr_o),
    .out_corr0_o       (out_corr0_o),
    .out_corr1_o       (out_corr1_o),
    .count_o           (count_o)
  );

  always #5 clk = ~clk;

  ifb_entry_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic bit bypass_on();
`ifdef IFB_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic ifb_entry_t slot(input bit two);
    ifb_entry_t e;
    if (two) e = '{corr: in_corr1_i, addr: in_inst2_addr_i, inst: in_inst2_i};
    else     e = '{corr: in_corr0_i, addr: in_inst1_addr_i, inst: in_inst1_i};
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of entries updated from the rules directly.
  always @(posedge clk or negedge rst) begin
    ifb_entry_t nw[$];
    int iss, sz0, k;
    if (!rst) q.delete();
    else if (flush_i) q.delete();
    else begin
      nw.delete();
      if (in_inst1_valid_i) nw.push_back(slot(1'b0));
      if (in_inst1_valid_i && in_inst2_valid_i) nw.push_back(slot(1'b1));
      iss = (issue_cnt_i > 2'd2) ? 2 : int'(issue_cnt_i);
      sz0 = q.size();
      if (nw.size() <= D - sz0) begin
        if (bypass_on() && sz0 == 0) begin
          k = (iss < nw.size()) ? iss : nw.size();
          repeat (k) void'(nw.pop_front());
        end
        foreach (nw[j]) q.push_back(nw[j]);
      end
      k = (iss < sz0) ? iss : sz0;
      repeat (k) void'(q.pop_front());
    end
  end

  // Monitor: compare DUT outputs against the model away from the edge.
  always @(negedge clk) begin
    ifb_entry_t x1, x2;
    bit v1, v2;
    x1 = '0;
    x2 = '0;
    if (bypass_on() && rst && !flush_i && q.size() == 0) begin
      v1 = in_inst1_valid_i;
      v2 = in_inst1_valid_i && in_inst2_valid_i;
      if (v1) x1 = slot(1'b0);
      if (v2) x2 = slot(1'b1);
    end else begin
      v1 = q.size() >= 1;
      v2 = q.size() >= 2;
      if (v1) x1 = q[0];
      if (v2) x2 = q[1];
    end
    cmp("count", 64'(count_o), 64'(q.size()));
    cmp("full", 64'(fetch_full_o), 64'((D - q.size()) < IFB_FULL_THRESH));
    cmp("v1", 64'(out_inst1_valid_o), 64'(v1));
    cmp("v2", 64'(out_inst2_valid_o), 64'(v2));
    cmp("inst1", 64'(out_inst1_o), 64'(x1.inst));
    cmp("addr1", 64'(out_inst1_addr_o), 64'(x1.addr));
    cmp("corr0", 64'(out_corr0_o), 64'(x1.corr));
    cmp("inst2", 64'(out_inst2_o), 64'(x2.inst));
    cmp("addr2", 64'(out_inst2_addr_o), 64'(x2.addr));
    cmp("corr1", 64'(out_corr1_o), 64'(x2.corr));
  end

  task automatic drive(input bit v1, input bit v2, input logic [1:0] iss,
                       input bit fl, input logic [31:0] pc);
    in_inst1_valid_i = v1;
    in_inst2_valid_i = v2;
    in_inst1_i       = $urandom;
    in_inst2_i       = $urandom;
    in_inst1_addr_i  = pc;
    in_inst2_addr_i  = pc + 32'd4;
    in_corr0_i       = IFB_CORR_W'($urandom);
    in_corr1_i       = IFB_CORR_W'($urandom);
    issue_cnt_i      = iss;
    flush_i          = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    bit can, v1;
    logic [1:0] iss;
    rst = 1'b0;
    flush_i = 1'b0;
    in_inst1_valid_i = 1'b0;
    in_inst2_valid_i = 1'b0;
    issue_cnt_i = 2'd0;
    repeat (3) drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h0);
    rst = 1'b1;
    pc = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd0, 1'b0, pc);
      pc += 32'd8;
    end
    drive(1'b0, 1'b1, 2'd0, 1'b0, pc);
    drive(1'b1, 1'b0, 2'd0, 1'b0, pc);
    pc += 32'd4;
    while (q.size() <= D - IFB_FULL_THRESH) begin
      drive(1'b1, 1'b1, 2'd0, 1'b0, pc);
      pc += 32'd8;
    end
    drive(1'b0, 1'b0, 2'd2, 1'b0, pc);
    drive(1'b0, 1'b0, 2'd3, 1'b0, pc);
    drive(1'b1, 1'b1, 2'd2, 1'b1, pc);
    drive(1'b1, 1'b1, 2'd1, 1'b0, pc);
    drive(1'b0, 1'b0, 2'd3, 1'b0, pc);
    for (int i = 0; i < 3000; i++) begin
      can = q.size() <= D - IFB_FULL_THRESH;
      v1  = can && ($urandom_range(3) != 0);
      iss = ((i / 200) % 2 == 1) ? 2'($urandom_range(1))
                                 : 2'($urandom_range(3));
      if (i == 1500) begin
        #2 rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, pc);
        rst = 1'b1;
      end
      drive(v1, 1'($urandom), iss, ($urandom_range(39) == 0), pc);
      pc += 32'd8;
    end
    drive(1'b0, 1'b0, 2'd0, 1'b0, pc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
